ucb_fill_unit: RTL and testbench

Downstream of the clause-table/evaluator stage. Each cycle this block samples the 20-lane `write_req` mask and the 720-bit `temp_out_noc` bus that the stage produces. It serializes the requested lanes, lowest lane first, into a circular unsatisfied-clause FIFO. The FIFO is drained by the clause register through a show-ahead valid/ready port.

---
 rtl/ucb_fill_unit_if.sv | 28 ++
 rtl/ucb_fill_unit.sv | 125 ++++++++++++
 tb/tb_ucb_fill_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucb_fill_unit_if.sv
// Bus between the evaluator stage, the fill unit and the clause-register consumer.
// The slave modport is the fill unit itself.
interface ucb_fill_unit_if #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned CW    = 36,
   parameter int unsigned AW    = $clog2(DEPTH)
);
   logic [1:20]      write_req;
   logic [20*CW-1:0] lane_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_clause;
   logic [AW:0]      count;
   logic             full;
   logic             empty;
   logic             busy;
   logic             lost;

   modport master (
      output write_req, lane_data, out_ready,
      input  out_valid, out_clause, count, full, empty, busy, lost
   );

   modport slave (
      input  write_req, lane_data, out_ready,
      output out_valid, out_clause, count, full, empty, busy, lost
   );
endinterface

// File: rtl/ucb_fill_unit.sv
// Serializes requested evaluator lanes, lowest lane first, into a circular
// unsatisfied-clause FIFO drained through a show-ahead valid/ready port.
module ucb_fill_unit #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned CW    = 36,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input logic         clk,
   input logic         rst,
   ucb_fill_unit_if.slave bus_io
);

   localparam int unsigned NumLanes = 20;

   typedef enum logic [0:0] {StIdle, StDrain} state_e;

   state_e              state_q, state_d;
   logic [1:NumLanes]   pend_q, pend_d;
   logic [CW-1:0]       cap_q [1:NumLanes];
   logic [CW-1:0]       mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [AW:0]         count_q, count_d;
   logic                lost_q, lost_d;

   logic                capture, push, pop, full, empty, found;
   logic [1:NumLanes]   sel_oh;
   logic [CW-1:0]       wdata;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && bus_io.out_ready;

   // Lowest pending lane wins.
   always_comb begin
      sel_oh = '0;
      wdata  = '0;
      found  = 1'b0;
      for (int k = 1; k <= NumLanes; k++) begin
         if (pend_q[k] && !found) begin
            sel_oh[k] = 1'b1;
            wdata     = cap_q[k];
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      lost_d  = lost_q;
      capture = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|bus_io.write_req) begin
               capture = 1'b1;
               pend_d  = bus_io.write_req;
               state_d = StDrain;
            end
         end
         StDrain: begin
            push = !full && found;
            if (push) pend_d = pend_q & ~sel_oh;
            // Only the final-write edge may accept a new request.
            if (push && (pend_d == '0)) begin
               if (|bus_io.write_req) begin
                  capture = 1'b1;
                  pend_d  = bus_io.write_req;
               end else begin
                  state_d = StIdle;
               end
            end else if (|bus_io.write_req) begin
               lost_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_q + AW'(push);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_d;
         lost_q   <= lost_d;
      end
   end

   // Storage is never cleared; the pointers hide stale contents after reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
      if (capture) begin
         for (int k = 1; k <= NumLanes; k++) begin
            cap_q[k] <= bus_io.lane_data[CW*(NumLanes-k) +: CW];
         end
      end
   end

   assign bus_io.out_valid  = !empty;
   assign bus_io.out_clause = empty ? '0 : mem_q[rd_ptr_q];
   assign bus_io.count      = count_q;
   assign bus_io.full       = full;
   assign bus_io.empty      = empty;
   assign bus_io.busy       = (state_q == StDrain);
   assign bus_io.lost       = lost_q;

endmodule

// File: tb/tb_ucb_fill_unit.sv
// Directed self-checking bench for ucb_fill_unit; inputs change 1 time unit
// after each rising edge, outputs are sampled at the same point.
module tb_ucb_fill_unit;

   localparam int unsigned DEPTH = 2048;
   localparam int unsigned CW    = 36;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   ucb_fill_unit_if #(.DEPTH(DEPTH), .CW(CW)) intf ();

   ucb_fill_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (intf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int k, input logic [CW-1:0] d);
      intf.lane_data[CW*(20-k) +: CW] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      intf.write_req = '0;
      intf.lane_data = '0;
      intf.out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tests++; if (intf.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", intf.out_valid); end
      tests++; if (intf.out_clause !== '0) begin fails++; $display("FAIL reset_clause: got %h want 0", intf.out_clause); end
      tests++; if (intf.count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", intf.count); end
      tests++; if (intf.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", intf.full); end
      tests++; if (intf.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", intf.empty); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", intf.busy); end
      tests++; if (intf.lost !== 1'b0) begin fails++; $display("FAIL reset_lost: got %b want 0", intf.lost); end
   endtask

   task automatic test_single_lane();
      intf.write_req = '0;
      intf.write_req[3] = 1'b1;
      set_lane(3, 36'h0AB_123_456);
      tick();
      intf.write_req = '0;
      tests++; if (intf.busy !== 1'b1) begin fails++; $display("FAIL single_busy_on: got %b want 1", intf.busy); end
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL single_count0: got %0d want 0", intf.count); end
      tick();
      tests++; if (intf.count !== 12'd1) begin fails++; $display("FAIL single_count1: got %0d want 1", intf.count); end
      tests++; if (intf.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b want 1", intf.out_valid); end
      tests++; if (intf.out_clause !== 36'h0AB123456) begin fails++; $display("FAIL single_clause: got %h want 0ab123456", intf.out_clause); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL single_busy_off: got %b want 0", intf.busy); end
      intf.out_ready = 1'b1;
      tick();
      intf.out_ready = 1'b0;
      tests++; if (intf.empty !== 1'b1) begin fails++; $display("FAIL single_pop_empty: got %b want 1", intf.empty); end
   endtask

   task automatic test_multi_lane();
      int lanes [3] = '{1, 7, 20};
      logic [CW-1:0] tag;
      tag = 36'h5A5000000;
      intf.write_req = '0;
      foreach (lanes[j]) begin
         intf.write_req[lanes[j]] = 1'b1;
         set_lane(lanes[j], tag | CW'(lanes[j]));
      end
      tick();
      intf.write_req = '0;
      tick();
      tests++; if (intf.count !== 12'd1) begin fails++; $display("FAIL multi_count1: got %0d want 1", intf.count); end
      tick();
      tick();
      tests++; if (intf.count !== 12'd3) begin fails++; $display("FAIL multi_count3: got %0d want 3", intf.count); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL multi_busy: got %b want 0", intf.busy); end
      tick();
      tests++; if (intf.count !== 12'd3) begin fails++; $display("FAIL multi_peak: got %0d want 3", intf.count); end
      foreach (lanes[j]) begin
         tests++;
         if (intf.out_clause !== (tag | CW'(lanes[j]))) begin
            fails++;
            $display("FAIL multi_order[%0d]: got %h want %h", j, intf.out_clause, tag | CW'(lanes[j]));
         end
         intf.out_ready = 1'b1;
         tick();
         intf.out_ready = 1'b0;
      end
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL multi_count_end: got %0d want 0", intf.count); end
   endtask

   task automatic test_full_stall();
      logic [CW-1:0] fill;
      logic [CW-1:0] want [3];
      fill    = 36'h111111111;
      want[0] = 36'h222000002;
      want[1] = 36'h222000003;
      want[2] = 36'h222000004;
      // Back-to-back single-lane requests push one entry per edge.
      intf.write_req = '0;
      intf.write_req[1] = 1'b1;
      set_lane(1, fill);
      repeat (DEPTH - 1) tick();
      intf.write_req = '0;
      tick();
      tests++; if (intf.count !== 12'(DEPTH - 1)) begin fails++; $display("FAIL stall_prefill: got %0d want %0d", intf.count, DEPTH - 1); end
      tests++; if (intf.full !== 1'b0) begin fails++; $display("FAIL stall_prefill_full: got %b want 0", intf.full); end
      for (int k = 2; k <= 4; k++) begin
         intf.write_req[k] = 1'b1;
         set_lane(k, want[k-2]);
      end
      tick();
      intf.write_req = '0;
      tick();
      tests++; if (intf.count !== 12'(DEPTH)) begin fails++; $display("FAIL stall_full_count: got %0d want %0d", intf.count, DEPTH); end
      tests++; if (intf.full !== 1'b1) begin fails++; $display("FAIL stall_full: got %b want 1", intf.full); end
      tick();
      tick();
      tests++; if (intf.count !== 12'(DEPTH)) begin fails++; $display("FAIL stall_hold_count: got %0d want %0d", intf.count, DEPTH); end
      tests++; if (intf.busy !== 1'b1) begin fails++; $display("FAIL stall_hold_busy: got %b want 1", intf.busy); end
      for (int p = 0; p < 2; p++) begin
         intf.out_ready = 1'b1;
         tick();
         intf.out_ready = 1'b0;
         tests++; if (intf.count !== 12'(DEPTH - 1)) begin fails++; $display("FAIL stall_pop%0d_count: got %0d want %0d", p, intf.count, DEPTH - 1); end
         tests++; if (intf.busy !== 1'b1) begin fails++; $display("FAIL stall_pop%0d_busy: got %b want 1", p, intf.busy); end
         tick();
         tests++; if (intf.count !== 12'(DEPTH)) begin fails++; $display("FAIL stall_refill%0d: got %0d want %0d", p, intf.count, DEPTH); end
      end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL stall_done_busy: got %b want 0", intf.busy); end
      tests++; if (intf.lost !== 1'b0) begin fails++; $display("FAIL stall_lost: got %b want 0", intf.lost); end
      intf.out_ready = 1'b1;
      repeat (DEPTH - 3) tick();
      intf.out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tests++; if (intf.out_clause !== want[j]) begin fails++; $display("FAIL stall_tail[%0d]: got %h want %h", j, intf.out_clause, want[j]); end
         intf.out_ready = 1'b1;
         tick();
         intf.out_ready = 1'b0;
      end
      // Popping while empty must not underflow.
      intf.out_ready = 1'b1;
      tick();
      tick();
      intf.out_ready = 1'b0;
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL stall_underflow: got %0d want 0", intf.count); end
      tests++; if (intf.out_clause !== '0) begin fails++; $display("FAIL stall_empty_clause: got %h want 0", intf.out_clause); end
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] want [6];
      want = '{36'hD00000001, 36'hD00000002, 36'hE00000006,
               36'hF00000001, 36'hF00000002, 36'hF00000003};
      intf.write_req = '0;
      intf.write_req[1] = 1'b1;
      intf.write_req[2] = 1'b1;
      set_lane(1, want[0]);
      set_lane(2, want[1]);
      tick();
      intf.write_req = '0;
      tick();
      tests++; if (intf.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_mid: got %b want 1", intf.busy); end
      intf.write_req[6] = 1'b1;
      set_lane(6, want[2]);
      tick();
      intf.write_req = '0;
      tests++; if (intf.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_gap: got %b want 1", intf.busy); end
      tests++; if (intf.lost !== 1'b0) begin fails++; $display("FAIL b2b_lost: got %b want 0", intf.lost); end
      tests++; if (intf.count !== 12'd2) begin fails++; $display("FAIL b2b_count2: got %0d want 2", intf.count); end
      tick();
      tests++; if (intf.count !== 12'd3) begin fails++; $display("FAIL b2b_count3: got %0d want 3", intf.count); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b want 0", intf.busy); end
      // Second drain: a request on its first write edge is dropped.
      for (int k = 1; k <= 3; k++) begin
         intf.write_req[k] = 1'b1;
         set_lane(k, want[2+k]);
      end
      tick();
      intf.write_req = '0;
      intf.write_req[5] = 1'b1;
      set_lane(5, 36'hBADBADBAD);
      tick();
      intf.write_req = '0;
      tests++; if (intf.lost !== 1'b1) begin fails++; $display("FAIL drop_lost: got %b want 1", intf.lost); end
      tick();
      tick();
      tests++; if (intf.count !== 12'd6) begin fails++; $display("FAIL drop_count: got %0d want 6", intf.count); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL drop_busy: got %b want 0", intf.busy); end
      for (int j = 0; j < 6; j++) begin
         tests++; if (intf.out_clause !== want[j]) begin fails++; $display("FAIL drop_order[%0d]: got %h want %h", j, intf.out_clause, want[j]); end
         intf.out_ready = 1'b1;
         tick();
         intf.out_ready = 1'b0;
      end
      tests++; if (intf.empty !== 1'b1) begin fails++; $display("FAIL drop_empty: got %b want 1", intf.empty); end
   endtask

   task automatic test_wrap();
      int n_rx;
      int bad;
      logic [CW-1:0] tag;
      tag  = 36'hC00000000;
      n_rx = 0;
      bad  = 0;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
      intf.out_ready = 1'b1;
      for (int i = 0; i < 3 * DEPTH + 4; i++) begin
         if (intf.out_valid === 1'b1) begin
            tests++;
            if (intf.out_clause !== (tag | CW'(n_rx))) begin
               fails++;
               if (bad < 5) $display("FAIL wrap_data[%0d]: got %h want %h", n_rx, intf.out_clause, tag | CW'(n_rx));
               bad++;
            end
            n_rx++;
         end
         tests++;
         if (intf.count > 1) begin
            fails++;
            if (bad < 5) $display("FAIL wrap_count@%0d: got %0d want <=1", i, intf.count);
            bad++;
         end
         intf.write_req = '0;
         if (i < 3 * DEPTH) begin
            intf.write_req[1] = 1'b1;
            set_lane(1, tag | CW'(i));
         end
         tick();
      end
      intf.out_ready = 1'b0;
      tests++; if (n_rx != 3 * DEPTH) begin fails++; $display("FAIL wrap_total: got %0d want %0d", n_rx, 3 * DEPTH); end
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL wrap_final_count: got %0d want 0", intf.count); end
      tests++; if (intf.lost !== 1'b0) begin fails++; $display("FAIL wrap_lost: got %b want 0", intf.lost); end
   endtask

   task automatic test_mid_reset();
      intf.write_req = '0;
      for (int k = 1; k <= 10; k++) begin
         intf.write_req[k] = 1'b1;
         set_lane(k, 36'h700000000 | CW'(k));
      end
      tick();
      intf.write_req = '0;
      intf.write_req[15] = 1'b1;
      tick();
      intf.write_req = '0;
      tick();
      tests++; if (intf.lost !== 1'b1) begin fails++; $display("FAIL midrst_pre_lost: got %b want 1", intf.lost); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", intf.count); end
      tests++; if (intf.empty !== 1'b1) begin fails++; $display("FAIL midrst_empty: got %b want 1", intf.empty); end
      tests++; if (intf.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", intf.busy); end
      tests++; if (intf.lost !== 1'b0) begin fails++; $display("FAIL midrst_lost: got %b want 0", intf.lost); end
      tick();
      tick();
      tests++; if (intf.count !== 12'd0) begin fails++; $display("FAIL midrst_no_resume: got %0d want 0", intf.count); end
      tests++; if (intf.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", intf.out_valid); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single_lane();
      test_multi_lane();
      test_full_stall();
      test_back_to_back();
      test_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
